spi_minion: RTL and testbench

SPI mode-0 peripheral-side endpoint that sits directly downstream of `spi_master`: it consumes the `cs`/`sclk`/`mosi` wires the master drives and returns `miso`. It synchronises the SPI wires into the local clock domain and deserialises MOSI into `nbits`-wide words. Each received word is presented on a val/rdy send interface. Words the local core pushes through a val/rdy recv interface are serialised back on MISO during the next word slot.

---
 rtl/spi_pkg.sv | 12 +
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_minion.sv | 135 +++++++++++++
 tb/tb_spi_minion.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI minion endpoint
package spi_pkg;

  localparam int SYNC_DEPTH = 2;

  typedef enum logic [1:0] {
    WAIT_HIGH,
    IDLE,
    ACTIVE
  } spi_minion_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - two-flop synchroniser plus history flop for edge pulses
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic pos,
  output logic neg
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_DEPTH{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
      hist_q <= sync_q[SYNC_DEPTH-1];
    end
  end

  assign level = sync_q[SYNC_DEPTH-1];
  assign pos   = level & ~hist_q;
  assign neg   = ~level & hist_q;

endmodule

// File: rtl/spi_minion.sv
// rtl/spi_minion.sv - SPI mode-0 endpoint: MOSI words to send port, recv port words to MISO
module spi_minion
  import spi_pkg::*;
#(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cs,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  input  logic [nbits-1:0] recv_msg,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic [nbits-1:0] send_msg,
  output logic             send_val,
  input  logic             send_rdy,
  output logic             overflow
);

  localparam int CNT_W    = $clog2(nbits + 1);
  localparam int SETTLE_W = $clog2(SYNC_DEPTH + 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_pos, sclk_neg;
  logic mosi_lvl, mosi_pos, mosi_neg;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din(cs), .level(cs_lvl), .pos(cs_rise), .neg(cs_fall)
  );
  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(sclk), .level(sclk_lvl), .pos(sclk_pos), .neg(sclk_neg)
  );
  spi_sync_edge #(.RESET_VAL(1'b0)) u_mosi_sync (
    .clk(clk), .reset(reset), .din(mosi), .level(mosi_lvl), .pos(mosi_pos), .neg(mosi_neg)
  );

  logic unused_edges;
  assign unused_edges = ^{sclk_lvl, mosi_pos, mosi_neg};

  spi_minion_state_t     state_q;
  logic [SETTLE_W-1:0]   settle_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [nbits-1:0]      rx_sr_q;
  logic [nbits-1:0]      tx_sr_q;
  logic [nbits-1:0]      tx_buf_q;
  logic                  tx_full_q;
  logic                  send_full_q;
  logic                  overflow_q;

  logic                  settled;
  logic                  word_done;
  logic                  load;
  logic                  send_hs;
  logic                  recv_hs;
  logic [nbits-1:0]      rx_word;
  logic [nbits-1:0]      load_word;

  // cs level is trusted only once the chain holds real pin samples, not reset values
  assign settled   = (settle_q == SETTLE_W'(SYNC_DEPTH));
  assign word_done = (state_q == ACTIVE) && !cs_rise && sclk_pos && (cnt_q == CNT_W'(nbits - 1));
  assign load      = ((state_q == IDLE) && cs_fall) || word_done;
  assign send_hs   = send_full_q & send_rdy;
  assign recv_hs   = recv_val & ~tx_full_q;
  assign rx_word   = {rx_sr_q[nbits-2:0], mosi_lvl};
  assign load_word = tx_full_q ? tx_buf_q : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= WAIT_HIGH;
      settle_q    <= '0;
      cnt_q       <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '0;
      tx_buf_q    <= '0;
      tx_full_q   <= 1'b0;
      send_msg    <= '0;
      send_full_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (!settled) settle_q <= settle_q + SETTLE_W'(1);

      // a load consumes the pre-handshake buffer; a new word waits for the next slot
      tx_full_q <= (tx_full_q & ~load) | recv_hs;
      if (recv_hs) tx_buf_q <= recv_msg;

      if (word_done && (!send_full_q || send_hs)) begin
        send_msg    <= rx_word;
        send_full_q <= 1'b1;
      end else if (send_hs) begin
        send_full_q <= 1'b0;
      end
      if (word_done && send_full_q && !send_hs) overflow_q <= 1'b1;

      case (state_q)
        WAIT_HIGH: begin
          if (settled && cs_lvl) state_q <= IDLE;
        end
        IDLE: begin
          if (cs_fall) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            tx_sr_q <= load_word;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tx_sr_q <= '0;
          end else if (sclk_pos) begin
            rx_sr_q <= rx_word;
            if (word_done) begin
              cnt_q   <= '0;
              tx_sr_q <= load_word;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (sclk_neg && cnt_q != '0) begin
            // count 0 means a fresh word was just loaded; keep its MSB on the wire
            tx_sr_q <= {tx_sr_q[nbits-2:0], 1'b0};
          end
        end
        default: state_q <= WAIT_HIGH;
      endcase
    end
  end

  assign miso     = tx_sr_q[nbits-1];
  assign recv_rdy = ~tx_full_q;
  assign send_val = send_full_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_spi_minion.sv
// tb/tb_spi_minion.sv - directed bench for spi_minion with a word-level reference model
module tb_spi_minion;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b1;
  logic       sclk = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] recv_msg = 8'h00;
  logic       recv_val = 1'b0;
  logic       recv_rdy;
  logic [7:0] send_msg;
  logic       send_val;
  logic       send_rdy = 1'b1;
  logic       overflow;

  int n_cmp = 0;
  int n_bad = 0;
  int hs_cnt = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  spi_minion #(.nbits(8)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy), .overflow(overflow)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pins are seen two edges late; words tracked as values plus bit positions.
  logic [2:0] m_h1, m_h2, m_h3;
  int         m_nsamp;
  bit         m_armed, m_in_frame;
  int         m_bits, m_tx_shifts;
  logic [7:0] m_rx, m_tx_word, m_txbuf, m_sendmsg;
  bit         m_txfull, m_sendfull, m_ovf;

  task automatic m_init();
    m_h1 = 3'b100; m_h2 = 3'b100; m_h3 = 3'b100; m_nsamp = 0;
    m_armed = 0; m_in_frame = 0; m_bits = 0; m_tx_shifts = 0;
    m_rx = 0; m_tx_word = 0; m_txbuf = 0; m_sendmsg = 0;
    m_txfull = 0; m_sendfull = 0; m_ovf = 0;
  endtask

  task automatic m_step();
    bit cs_l, cs_p, sc_l, sc_p, mo, fall, rise, spos, sneg, load, done, shs, rhs;
    cs_l = m_h2[2]; cs_p = m_h3[2]; sc_l = m_h2[1]; sc_p = m_h3[1]; mo = m_h2[0];
    fall = !cs_l && cs_p; rise = cs_l && !cs_p;
    spos = sc_l && !sc_p; sneg = !sc_l && sc_p;
    shs = m_sendfull && send_rdy;
    rhs = recv_val && !m_txfull;
    load = 0; done = 0;
    if (!m_armed) begin
      if (m_nsamp >= 2 && cs_l) m_armed = 1;
    end else if (!m_in_frame) begin
      if (fall) begin m_in_frame = 1; m_bits = 0; load = 1; end
    end else if (rise) begin
      m_in_frame = 0; m_bits = 0; m_tx_word = 0; m_tx_shifts = 0;
    end else if (spos) begin
      m_rx = {m_rx[6:0], mo};
      m_bits++;
      if (m_bits == 8) begin m_bits = 0; done = 1; load = 1; end
    end else if (sneg && m_bits != 0) begin
      m_tx_shifts++;
    end
    if (done) begin
      if (m_sendfull && !shs) m_ovf = 1;
      else begin m_sendmsg = m_rx; m_sendfull = 1; end
    end else if (shs) begin
      m_sendfull = 0;
    end
    if (load) begin
      m_tx_word = m_txfull ? m_txbuf : 8'h00;
      m_tx_shifts = 0;
      m_txfull = 0;
    end
    if (rhs) begin m_txbuf = recv_msg; m_txfull = 1; end
    m_h3 = m_h2; m_h2 = m_h1; m_h1 = {cs, sclk, mosi};
    if (m_nsamp < 3) m_nsamp++;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) m_init();
    else m_step();
  end

  function automatic int exp_miso();
    if (m_tx_shifts >= 8) return 0;
    return int'(m_tx_word[7 - m_tx_shifts]);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("miso", int'(miso), exp_miso());
      check("send_val", int'(send_val), int'(m_sendfull));
      check("send_msg", int'(send_msg), int'(m_sendmsg));
      check("recv_rdy", int'(recv_rdy), int'(!m_txfull));
      check("overflow", int'(overflow), int'(m_ovf));
      if (send_val && send_rdy) hs_cnt++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] w, input int n, input bit chk, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi = w[7-i];
      cyc(HALF);
      got = {got[6:0], miso};
      sclk = 1'b1;
      if (chk && i == n - 1) begin
        for (int k = 1; k <= 5; k++) begin
          @(negedge clk);
          check("send_val_timing", int'(send_val), (k == 4) ? 1 : 0);
        end
      end
      cyc(HALF);
      sclk = 1'b0;
    end
  endtask

  logic [7:0] g1, g2;
  int         hs0;

  initial begin
    cyc(2);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_miso", int'(miso), 0);
    check("reset_send_val", int'(send_val), 0);
    check("reset_send_msg", int'(send_msg), 0);
    check("reset_recv_rdy", int'(recv_rdy), 1);
    check("reset_overflow", int'(overflow), 0);
    cyc(1);
    reset = 1'b1;
    cyc(8);

    // basic receive
    hs0 = hs_cnt;
    cs = 1'b0;
    spi_bits(8'hA5, 8, 1'b1, g1);
    cs = 1'b1;
    cyc(8);
    check("basic_pulses", hs_cnt - hs0, 1);
    check("basic_msg", int'(send_msg), 8'hA5);
    check("basic_overflow", int'(overflow), 0);

    // full duplex
    recv_msg = 8'h3C; recv_val = 1'b1;
    cyc(1);
    recv_val = 1'b0;
    check("dup_rdy_low", int'(recv_rdy), 0);
    cs = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      check("dup_rdy_return", int'(recv_rdy), (k == 4) ? 1 : 0);
    end
    spi_bits(8'hFF, 8, 1'b0, g1);
    cs = 1'b1;
    cyc(8);
    check("dup_miso_bits", int'(g1), 8'h3C);
    check("dup_msg", int'(send_msg), 8'hFF);

    // back-to-back words in one frame
    cs = 1'b0;
    spi_bits(8'h01, 8, 1'b0, g1);
    check("b2b_first", int'(send_msg), 8'h01);
    spi_bits(8'h80, 8, 1'b0, g2);
    cs = 1'b1;
    cyc(8);
    check("b2b_miso0", int'(g1), 0);
    check("b2b_miso1", int'(g2), 0);
    check("b2b_second", int'(send_msg), 8'h80);

    // overflow
    send_rdy = 1'b0;
    cs = 1'b0;
    spi_bits(8'h11, 8, 1'b0, g1);
    spi_bits(8'h22, 8, 1'b0, g1);
    cs = 1'b1;
    cyc(8);
    check("ovf_msg", int'(send_msg), 8'h11);
    check("ovf_flag", int'(overflow), 1);
    send_rdy = 1'b1;
    cyc(4);
    check("ovf_sticky", int'(overflow), 1);
    check("ovf_drained", int'(send_val), 0);

    // abort after five bits, then a clean word proves the counter restarted
    hs0 = hs_cnt;
    cs = 1'b0;
    spi_bits(8'hF8, 5, 1'b0, g1);
    cs = 1'b1;
    cyc(10);
    check("abort_no_word", hs_cnt - hs0, 0);
    cs = 1'b0;
    spi_bits(8'h5A, 8, 1'b0, g1);
    cs = 1'b1;
    cyc(8);
    check("abort_next_word", int'(send_msg), 8'h5A);

    // reset mid-frame, released with cs still low
    cs = 1'b0;
    spi_bits(8'hE0, 3, 1'b0, g1);
    reset = 1'b0;
    cyc(2);
    reset = 1'b1;
    hs0 = hs_cnt;
    spi_bits(8'h77, 8, 1'b0, g1);
    cyc(6);
    check("rst_frame_ignored", hs_cnt - hs0, 0);
    check("rst_msg_clear", int'(send_msg), 0);
    cs = 1'b1;
    cyc(8);
    cs = 1'b0;
    spi_bits(8'h66, 8, 1'b0, g1);
    cs = 1'b1;
    cyc(8);
    check("rst_new_frame", hs_cnt - hs0, 1);
    check("rst_new_msg", int'(send_msg), 8'h66);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
